// File: rtl/nim_sum_ctrl.sv
// nim_sum_ctrl: control sequencer for the regsFile/alu/dataMem datapath.
//   Streams NUM_DIGITS decimal digits into BASE_REG.., sums them into ACC_REG,
//   stores the sum to dataMem[MEM_ADDR] and reads it back onto sum_out.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      begin a run (sampled in IDLE only)
//   digit_valid/digit_ready    digit stream handshake, digit_in = 0..9
//   mem_data                   dataMem read data
//   rgr1/rgr2/rgw1             regsFile read/write addresses
//   immediate/aluSrc/aluCtrl   alu operand select and op (always add)
//   regWrite/memWrite/memRead  datapath strobes; address = dataMem address
//   busy/done/err/sum_out      status and result
module nim_sum_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BASE_REG   = 20,
    parameter int unsigned ACC_REG    = 31,
    parameter int unsigned MEM_ADDR   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        digit_valid,
    input  logic [3:0]  digit_in,
    output logic        digit_ready,
    input  logic [31:0] mem_data,
    output logic [4:0]  rgr1,
    output logic [4:0]  rgr2,
    output logic [4:0]  rgw1,
    output logic [31:0] immediate,
    output logic        aluSrc,
    output logic [3:0]  aluCtrl,
    output logic        regWrite,
    output logic        memWrite,
    output logic        memRead,
    output logic [31:0] address,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] sum_out
);

    localparam logic [4:0]  BaseReg = 5'(BASE_REG);
    localparam logic [4:0]  AccReg  = 5'(ACC_REG);
    localparam logic [31:0] MemAddr = 32'(MEM_ADDR);
    localparam logic [3:0]  LastIdx = 4'(NUM_DIGITS - 1);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StLdWait = 4'd1;
    localparam logic [3:0] StLdWr   = 4'd2;
    localparam logic [3:0] StClrSet = 4'd3;
    localparam logic [3:0] StClrWr  = 4'd4;
    localparam logic [3:0] StAccSet = 4'd5;
    localparam logic [3:0] StAccWr  = 4'd6;
    localparam logic [3:0] StStSet  = 4'd7;
    localparam logic [3:0] StStWr   = 4'd8;
    localparam logic [3:0] StRd     = 4'd9;
    localparam logic [3:0] StDone   = 4'd10;

    logic [3:0]  state_q, state_d;
    logic [3:0]  i_q, i_d;
    logic [3:0]  imm_q, imm_d;
    logic        err_q, err_d;
    logic [31:0] sum_q, sum_d;
    logic [4:0]  digit_reg;

    assign digit_reg = BaseReg + {1'b0, i_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            imm_q   <= '0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        imm_d   = imm_q;
        err_d   = err_q;
        sum_d   = sum_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLdWait;
                    i_d     = '0;
                    err_d   = 1'b0;
                end
            end
            StLdWait: begin
                if (digit_valid) begin
                    if (digit_in > 4'd9) begin
                        // Bad digit is consumed and the run is abandoned.
                        err_d   = 1'b1;
                        i_d     = '0;
                        state_d = StIdle;
                    end else begin
                        imm_d   = digit_in;
                        state_d = StLdWr;
                    end
                end
            end
            StLdWr: begin
                if (i_q == LastIdx) begin
                    i_d     = '0;
                    state_d = StClrSet;
                end else begin
                    i_d     = i_q + 4'd1;
                    state_d = StLdWait;
                end
            end
            StClrSet: state_d = StClrWr;
            StClrWr:  state_d = StAccSet;
            StAccSet: state_d = StAccWr;
            StAccWr: begin
                if (i_q == LastIdx) begin
                    i_d     = '0;
                    state_d = StStSet;
                end else begin
                    i_d     = i_q + 4'd1;
                    state_d = StAccSet;
                end
            end
            StStSet: state_d = StStWr;
            StStWr:  state_d = StRd;
            StRd: begin
                sum_d   = mem_data;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath controls are decoded from state alone so addresses are already
    // stable in the SET cycle preceding every strobe.
    always_comb begin
        digit_ready = 1'b0;
        rgr1        = '0;
        rgr2        = '0;
        rgw1        = '0;
        immediate   = '0;
        aluSrc      = 1'b0;
        regWrite    = 1'b0;
        memWrite    = 1'b0;
        memRead     = 1'b0;
        address     = '0;
        done        = 1'b0;
        case (state_q)
            StLdWait: begin
                digit_ready = 1'b1;
                aluSrc      = 1'b1;
                rgw1        = digit_reg;
                immediate   = {28'b0, digit_in};
            end
            StLdWr: begin
                aluSrc    = 1'b1;
                rgw1      = digit_reg;
                immediate = {28'b0, imm_q};
                regWrite  = 1'b1;
            end
            StClrSet, StClrWr: begin
                aluSrc   = 1'b1;
                rgw1     = AccReg;
                regWrite = (state_q == StClrWr);
            end
            StAccSet, StAccWr: begin
                rgr1     = AccReg;
                rgr2     = digit_reg;
                rgw1     = AccReg;
                regWrite = (state_q == StAccWr);
            end
            StStSet, StStWr: begin
                // acc + 0 puts the accumulator on aluResult for the store.
                aluSrc   = 1'b1;
                rgr1     = AccReg;
                address  = MemAddr;
                memWrite = (state_q == StStWr);
            end
            StRd: begin
                memRead = 1'b1;
                address = MemAddr;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign aluCtrl = 4'b0000;
    assign busy    = (state_q != StIdle);
    assign err     = err_q;
    assign sum_out = sum_q;

endmodule

// File: tb/tb_nim_sum_ctrl.sv
// tb_nim_sum_ctrl: bench for nim_sum_ctrl with a behavioural regsFile/alu/dataMem
// and a scoreboard of (expected sum, start cycle) entries popped on done.
module tb_nim_sum_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        digit_valid;
    logic [3:0]  digit_in;
    logic        digit_ready;
    logic [31:0] mem_data;
    logic [4:0]  rgr1, rgr2, rgw1;
    logic [31:0] immediate;
    logic        aluSrc;
    logic [3:0]  aluCtrl;
    logic        regWrite, memWrite, memRead;
    logic [31:0] address;
    logic        busy, done, err;
    logic [31:0] sum_out;

    nim_sum_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .digit_valid(digit_valid),
        .digit_in   (digit_in),
        .digit_ready(digit_ready),
        .mem_data   (mem_data),
        .rgr1       (rgr1),
        .rgr2       (rgr2),
        .rgw1       (rgw1),
        .immediate  (immediate),
        .aluSrc     (aluSrc),
        .aluCtrl    (aluCtrl),
        .regWrite   (regWrite),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .address    (address),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sum_out    (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model
    logic [31:0] regs [0:31];
    logic [31:0] mem  [0:15];
    logic [31:0] alu_a, alu_b, alu_y;

    always_comb begin
        alu_a    = (rgr1 == 5'd0) ? 32'd0 : regs[rgr1];
        alu_b    = aluSrc ? immediate : ((rgr2 == 5'd0) ? 32'd0 : regs[rgr2]);
        alu_y    = alu_a + alu_b;
        mem_data = memRead ? mem[address[3:0]] : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (regWrite && rgw1 != 5'd0) regs[rgw1] <= alu_y;
        if (memWrite) mem[address[3:0]] <= alu_y;
    end

    // Checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] sum;
        int          start_cyc;
    } sb_t;
    sb_t sb_q[$];

    int exp_lat;
    int rw_cnt = 0, mw_cnt = 0, done_cnt = 0, overlap_cnt = 0, alu_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (regWrite) rw_cnt++;
            if (memWrite) mw_cnt++;
            if (32'(regWrite) + 32'(memWrite) + 32'(memRead) > 1) overlap_cnt++;
            if (aluCtrl != 4'b0000) alu_bad++;
            if (done) begin
                sb_t e;
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sum_out", sum_out, e.sum);
                    check_eq("latency", 32'(cyc - e.start_cyc), 32'(exp_lat));
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] exp_sum, input int extra);
        sb_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e.sum       = exp_sum;
        e.start_cyc = cyc;
        exp_lat     = 29 + extra;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d, input int gap);
        int t;
        if (gap > 0) begin
            digit_valid = 1'b0;
            t = 0;
            while (!digit_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            repeat (gap) @(negedge clk);
        end
        digit_valid = 1'b1;
        digit_in    = d;
        t = 0;
        while (!digit_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_eq("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int t = 0;
        int c0 = done_cnt;
        while (done_cnt == c0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check_eq("done_timeout", 32'(t), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctrl"}, {20'd0, digit_ready, aluSrc, regWrite, memWrite, memRead,
                                  busy, done, err, aluCtrl}, 32'd0);
        check_eq({tag, "_addr"}, {17'd0, rgr1, rgr2, rgw1}, 32'd0);
        check_eq({tag, "_imm"}, immediate | address, 32'd0);
        check_eq({tag, "_sum"}, sum_out, 32'd0);
    endtask

    logic [3:0] digs [0:5];

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'd0;
        for (int k = 0; k < 16; k++) mem[k] = 32'd0;
        regs[31] = 32'h0000_1234;   // stale accumulator must be cleared by the run
        digs[0] = 4'd5; digs[1] = 4'd2; digs[2] = 4'd2;
        digs[3] = 4'd6; digs[4] = 4'd0; digs[5] = 4'd5;
        rst_n = 1'b0;
        start = 1'b0;
        digit_valid = 1'b0;
        digit_in = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Run 1: back-to-back digits
        rw_cnt = 0; mw_cnt = 0;
        do_start(32'd20, 0);
        for (int k = 0; k < 6; k++) send_digit(digs[k], 0);
        digit_valid = 1'b0;
        wait_done();
        for (int k = 0; k < 6; k++) check_eq($sformatf("reg%0d", 20 + k), regs[20 + k],
                                             {28'd0, digs[k]});
        check_eq("reg31", regs[31], 32'd20);
        check_eq("mem0", mem[0], 32'd20);
        check_eq("run1_regwrite_cnt", 32'(rw_cnt), 32'd13);
        check_eq("run1_memwrite_cnt", 32'(mw_cnt), 32'd1);
        check_eq("idle_after_done", {31'd0, busy}, 32'd0);

        // Run 2: three idle cycles before the fourth digit
        do_start(32'd20, 3);
        for (int k = 0; k < 6; k++) send_digit(digs[k], (k == 3) ? 3 : 0);
        digit_valid = 1'b0;
        wait_done();

        // Run 3: invalid digit aborts
        rw_cnt = 0; mw_cnt = 0;
        do_start(32'd0, 0);
        void'(sb_q.pop_back());     // no done expected for this run
        send_digit(4'd5, 0);
        send_digit(4'd2, 0);
        send_digit(4'd12, 0);
        digit_valid = 1'b0;
        check_eq("err_set", {31'd0, err}, 32'd1);
        check_eq("err_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check_eq("err_regwrite_cnt", 32'(rw_cnt), 32'd2);
        check_eq("err_memwrite_cnt", 32'(mw_cnt), 32'd0);
        check_eq("err_sticky", {31'd0, err}, 32'd1);
        check_eq("err_sum_held", sum_out, 32'd20);

        // Run 4: reset during ACC_WR of digit 3
        do_start(32'd20, 0);
        check_eq("err_cleared", {31'd0, err}, 32'd0);
        for (int k = 0; k < 6; k++) send_digit(digs[k], 0);
        digit_valid = 1'b0;
        begin
            int t = 0;
            while (!(regWrite && rgr2 == 5'd23) && t < 100) begin
                @(negedge clk);
                t++;
            end
            check_eq("acc3_reached", 32'(t < 100), 32'd1);
        end
        sb_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("midrun_reset");

        // Run 5: six nines, with start held high while busy
        do_start(32'd54, 0);
        send_digit(4'd9, 0);
        send_digit(4'd9, 0);
        start = 1'b1;
        for (int k = 2; k < 6; k++) send_digit(4'd9, 0);
        start = 1'b0;
        digit_valid = 1'b0;
        wait_done();
        check_eq("reg31_nines", regs[31], 32'd54);

        repeat (10) @(negedge clk);
        check_eq("done_count", 32'(done_cnt), 32'd3);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("strobe_overlap", 32'(overlap_cnt), 32'd0);
        check_eq("aluctrl_add", 32'(alu_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
